// File: rtl/crc8_frame_checker.sv
// Receive-side CRC-8 checker: recomputes CRC over each frame's payload, compares it with
// the trailing CRC byte, and reports a per-frame result plus saturating statistics.
`timescale 1ns/1ps

module crc8_frame_checker #(
    parameter logic [7:0] POLY    = 8'h07,
    parameter logic [7:0] INIT    = 8'h00,
    parameter bit         REFLECT = 1'b0,
    parameter logic [7:0] XOR_OUT = 8'h00,
    parameter int         MAX_LEN = 256,
    parameter int         LEN_W   = 9,
    parameter int         CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear_i,
    input  logic [7:0]       in_data_i,
    input  logic             in_valid_i,
    input  logic             in_last_i,
    output logic             in_ready_o,
    output logic             res_valid_o,
    output logic             res_ok_o,
    output logic [LEN_W-1:0] res_len_o,
    output logic [7:0]       res_crc_o,
    output logic [CNT_W-1:0] frame_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic             ovf_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DROP,
        S_RESULT
    } state_t;

    function automatic logic [7:0] bitrev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] d);
        logic [7:0] c;
        logic       fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
        end
        return c;
    endfunction

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    state_t           state_q, state_d;
    logic [7:0]       crc_q, crc_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             bad_q, bad_d;
    logic             res_ok_q, res_ok_d;
    logic [LEN_W-1:0] res_len_q;
    logic [7:0]       res_crc_q;
    logic [CNT_W-1:0] frame_cnt_q, err_cnt_q;
    logic             ovf_q;

    logic       accept;
    logic       capture;
    logic       set_ovf;
    logic [7:0] d_in;
    logic [7:0] crc_upd;
    logic [7:0] fin;

    assign in_ready_o  = (state_q != S_RESULT);
    assign res_valid_o = (state_q == S_RESULT);
    assign accept      = in_valid_i && in_ready_o;
    assign d_in        = REFLECT ? bitrev8(in_data_i) : in_data_i;
    assign crc_upd     = crc8_update(crc_q, d_in);
    assign fin         = (REFLECT ? bitrev8(crc_q) : crc_q) ^ XOR_OUT;

    // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        crc_d    = crc_q;
        len_d    = len_q;
        bad_d    = bad_q;
        capture  = 1'b0;
        set_ovf  = 1'b0;
        res_ok_d = res_ok_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (in_last_i) begin
                        capture = 1'b1;
                        state_d = S_RESULT;
                    end else begin
                        crc_d   = crc_upd;
                        len_d   = LEN_W'(1);
                        state_d = S_ACCUM;
                    end
                end
            end
            S_ACCUM: begin
                if (accept) begin
                    if (in_last_i) begin
                        capture = 1'b1;
                        state_d = S_RESULT;
                    end else if (len_q == LEN_MAX) begin
                        bad_d   = 1'b1;
                        set_ovf = 1'b1;
                        state_d = S_DROP;
                    end else begin
                        crc_d = crc_upd;
                        len_d = len_q + LEN_W'(1);
                    end
                end
            end
            S_DROP: begin
                if (accept && in_last_i) begin
                    capture = 1'b1;
                    state_d = S_RESULT;
                end
            end
            S_RESULT: begin
                crc_d   = INIT;
                len_d   = '0;
                bad_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // The CRC byte itself never enters the CRC; it is compared against the finalised register.
        if (capture) res_ok_d = !bad_d && (in_data_i == fin);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            crc_q     <= INIT;
            len_q     <= '0;
            bad_q     <= 1'b0;
            res_ok_q  <= 1'b0;
            res_len_q <= '0;
            res_crc_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            crc_q    <= crc_d;
            len_q    <= len_d;
            bad_q    <= bad_d;
            res_ok_q <= res_ok_d;
            if (capture) begin
                res_len_q <= len_q;
                res_crc_q <= fin;
            end
        end
    end

    // Statistics; clear_i wins over a same-cycle increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
            ovf_q       <= 1'b0;
        end else if (clear_i) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
            ovf_q       <= 1'b0;
        end else begin
            if (res_valid_o && !(&frame_cnt_q)) frame_cnt_q <= frame_cnt_q + CNT_W'(1);
            if (res_valid_o && !res_ok_q && !(&err_cnt_q)) err_cnt_q <= err_cnt_q + CNT_W'(1);
            if (set_ovf) ovf_q <= 1'b1;
        end
    end

    assign res_ok_o    = res_ok_q;
    assign res_len_o   = res_len_q;
    assign res_crc_o   = res_crc_q;
    assign frame_cnt_o = frame_cnt_q;
    assign err_cnt_o   = err_cnt_q;
    assign ovf_o       = ovf_q;

endmodule
